// File: rtl/spi_sclk_burst_gen.sv
// spi_sclk_burst_gen: SPI master SCLK burst and framing generator.
// Emits exactly N SCLK cycles per transaction with a runtime half-period,
// all four CPOL/CPHA modes, active-low chip select and shift/sample strobes.
// Optional guard timing (lead-in, trail and minimum cs-high gap) is built
// when SPI_SCLK_GUARD_EN is defined.
//
// state | meaning
// IDLE  | cs high, sclk follows live cpol, waiting for start with nbits!=0
// LEAD  | cs low for H cycles before the first edge (guard builds only)
// RUN   | toggling sclk every H cycles until 2N edges are produced
// TRAIL | cs held low for H cycles after the last edge (guard builds only)
// GAP   | cs high for H cycles, start ignored (guard builds only)
module spi_sclk_burst_gen #(
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 6,
  parameter int EDGE_W = CNT_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] half_div,
  input  logic [CNT_W-1:0] nbits,
  output logic             busy,
  output logic             done,
  output logic             cs_n_o,
  output logic             sclk_o,
  output logic             shift_stb,
  output logic             sample_stb
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_RUN   = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DIV_W-1:0]    r_h;
  logic [DIV_W-1:0]    r_hcnt;
  logic [CNT_W-1:0]    r_n;
  logic [EDGE_W-1:0]   r_edge;
  logic                r_cpha;
  logic                r_sclk;
  logic                r_done;
  logic                r_shift;
  logic                r_sample;

  logic                w_accept;
  logic                w_hwrap;
  logic                w_last;
  logic [EDGE_W-1:0]   w_two_n;
  logic [EDGE_W-1:0]   w_edge_nx;
  logic                w_leading;
  logic                w_shift_nx;
  logic                w_sample_nx;
  logic [DIV_W-1:0]    w_h_nx;

  assign w_accept    = start && (nbits != '0);
  assign w_hwrap     = (r_hcnt == r_h - DIV_W'(1));
  assign w_two_n     = {r_n, 1'b0};
  assign w_last      = (r_edge == w_two_n);
  assign w_edge_nx   = r_edge + EDGE_W'(1);
  // odd edge numbers move sclk away from the idle level
  assign w_leading   = w_edge_nx[0];
  // in CPHA=0 the first bit is preloaded, so the final trailing edge has no shift
  assign w_shift_nx  = r_cpha ? w_leading : (!w_leading && (w_edge_nx != w_two_n));
  assign w_sample_nx = r_cpha ? !w_leading : w_leading;
  assign w_h_nx      = (half_div == '0) ? DIV_W'(1) : half_div;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef SPI_SCLK_GUARD_EN
          w_next = S_LEAD;
`else
          w_next = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (w_last) begin
`ifdef SPI_SCLK_GUARD_EN
          w_next = S_TRAIL;
`else
          w_next = S_IDLE;
`endif
        end
      end
`ifdef SPI_SCLK_GUARD_EN
      S_LEAD:  if (w_hwrap) w_next = S_RUN;
      S_TRAIL: if (w_hwrap) w_next = S_GAP;
      S_GAP:   if (w_hwrap) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Framing outputs decoded from the current state
  always_comb begin
    busy   = 1'b0;
    cs_n_o = 1'b1;
    if ((r_state != S_IDLE) && (r_state != S_GAP)) begin
      busy   = 1'b1;
      cs_n_o = 1'b0;
    end
  end

  // Half-period/edge counters, sclk level, strobes and done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_h      <= '0;
      r_hcnt   <= '0;
      r_n      <= '0;
      r_edge   <= '0;
      r_cpha   <= 1'b0;
      r_sclk   <= 1'b0;
      r_done   <= 1'b0;
      r_shift  <= 1'b0;
      r_sample <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_shift  <= 1'b0;
      r_sample <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sclk <= cpol;
          r_hcnt <= '0;
          r_edge <= '0;
          if (w_accept) begin
            r_cpha <= cpha;
            r_h    <= w_h_nx;
            r_n    <= nbits;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_hcnt <= '0;
`ifndef SPI_SCLK_GUARD_EN
            r_done <= 1'b1;
`endif
          end else if (w_hwrap) begin
            r_hcnt   <= '0;
            r_edge   <= w_edge_nx;
            r_sclk   <= ~r_sclk;
            r_shift  <= w_shift_nx;
            r_sample <= w_sample_nx;
          end else begin
            r_hcnt <= r_hcnt + DIV_W'(1);
          end
        end
`ifdef SPI_SCLK_GUARD_EN
        S_LEAD, S_GAP: begin
          r_hcnt <= w_hwrap ? '0 : r_hcnt + DIV_W'(1);
        end
        S_TRAIL: begin
          r_hcnt <= w_hwrap ? '0 : r_hcnt + DIV_W'(1);
          if (w_hwrap) r_done <= 1'b1;
        end
`endif
        default: r_hcnt <= '0;
      endcase
    end
  end

  assign done       = r_done;
  assign sclk_o     = r_sclk;
  assign shift_stb  = r_shift;
  assign sample_stb = r_sample;

endmodule
